axrm8_seq_ctrl: RTL and testbench
=================================

Name: axrm8_seq_ctrl

Overview:
- Sequential 8x8 unsigned multiplier controller that time-multiplexes one 4x4 recursive multiplier core over four cycles.
- Splits operands into nibbles, feeds one nibble pair per cycle to the core, and shift-accumulates the partial products into a 16-bit result.
- Per-operation mode bit selects an exact or approximate 2x2 kernel inside the core.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- CNT_W, 16, width of the completed-operation counter (saturating).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair; high only in IDLE.
- in_a  in  8  multiplicand, unsigned.
- in_b  in  8  multiplier, unsigned.
- in_approx  in  1  1 = approximate kernel, 0 = exact; sampled at acceptance.
- out_valid  out  1  result valid; held until consumed.
- out_ready  in  1  consumer accepts result.
- out_p  out  16  product.
- busy  out  1  high in RUN or DONE.
- op_count  out  CNT_W  completed handshakes on the output side; saturates at all-ones.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_p=0, busy=0, op_count=0, step=0, accumulator=0.
- Reset asserted mid-operation aborts immediately; the operation is lost and no partial result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE: on in_valid&in_ready, latch a, b and approx; clear the accumulator; step=0; go to RUN.
- RUN, steps 0..3, one per cycle: core inputs are
  - step 0: (aL, bL), shift 0.
  - step 1: (aL, bH), shift 4.
  - step 2: (aH, bL), shift 4.
  - step 3: (aH, bH), shift 8.
  - Each cycle: acc <= acc + (core_p << shift), 16-bit, carries beyond bit 15 discarded (cannot occur in either mode).
  - After step 3 completes, go to DONE with out_valid=1 and out_p=acc.
- Latency: acceptance edge E0; steps at E1..E4; out_valid=1 visible after E4.
- DONE: out_p stable while out_valid=1. On out_valid&out_ready, go to IDLE, set out_valid=0, increment op_count (saturating).
- No input bypass in DONE. in_ready returns to 1 the cycle after the output handshake, so peak throughput is one operation per 6 cycles.
- in_valid while not in IDLE is ignored; operands are not sampled.
- in_a, in_b and in_approx may change freely after acceptance; latched copies are used.
- out_ready while out_valid=0 has no effect.
- Exact kernel: k(x,y)=x*y (2-bit operands, 4-bit result).
- Approximate kernel: k(x,y)=4*(x1&y1)+3*(x0&y0) (3-bit result).
- 4x4 core: P4 = k(L,L) + ((k(L,H)+k(H,L))<<2) + (k(H,H)<<4), 8-bit result.
- With exact k, P4 = a*b exactly.

Decomposition:
- Shared package axrm_pkg:
  - FSM state enum {IDLE, RUN, DONE}.
  - Step shift constants SHIFT_TBL = {0,4,4,8}.
  - Kernel-select encoding KERN_EXACT=0, KERN_APPROX=1.
- One sub-module, axrm4_core: purely combinational 4x4 recursive multiplier with a kernel-select input and 8-bit output.
- Controller, counter and accumulator stay in axrm8_seq_ctrl.

Test Plan:
- Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, out_p=0, op_count=0. Assert rst_n=0 during RUN step 2 -> outputs return to reset values at once; no out_valid afterwards.
- Exact: a=255, b=255, approx=0 -> out_valid 4 cycles after acceptance, out_p=65025. a=200, b=3 -> out_p=600.
- Approximate: a=255, b=255, approx=1 -> out_p=50575 (P4(15,15)=175; 175*289). a=2, b=3 -> 4. a=1, b=1 -> 3.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p held, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle, op_count +1.
- Operand change: after acceptance, drive in_a/in_b/in_approx with different values every cycle -> result matches the latched operands.
- Counter saturation: with CNT_W=2, complete 5 operations -> op_count=3.

Source files
------------

// File: rtl/axrm_pkg.sv
// Shared types and constants for the axrm sequential multiplier: FSM states,
// per-step partial-product shifts and kernel-select encoding.
package axrm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Index by step: step 0 -> 0, steps 1/2 -> 4, step 3 -> 8.
  localparam logic [3:0][3:0] SHIFT_TBL = {4'd8, 4'd4, 4'd4, 4'd0};

  localparam logic KERN_EXACT  = 1'b0;
  localparam logic KERN_APPROX = 1'b1;

endpackage

// File: rtl/axrm4_core.sv
// Combinational 4x4 recursive multiplier built from four 2x2 kernels;
// the kernel is either exact or a cheap approximation.
module axrm4_core
  import axrm_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       kern_sel_i,
  output logic [7:0] p_o
);

  // Approximate kernel drops the cross terms: 4*(x1&y1) + 3*(x0&y0).
  function automatic logic [3:0] kern(input logic [1:0] x, input logic [1:0] y,
                                      input logic sel);
    logic [3:0] r;
    if (sel == KERN_APPROX) begin
      r = {1'b0, x[1] & y[1], 2'b00} + ((x[0] & y[0]) ? 4'd3 : 4'd0);
    end else begin
      r = {2'b00, x} * {2'b00, y};
    end
    return r;
  endfunction

  logic [7:0] k_ll, k_lh, k_hl, k_hh;

  always_comb begin
    k_ll = {4'h0, kern(a_i[1:0], b_i[1:0], kern_sel_i)};
    k_lh = {4'h0, kern(a_i[1:0], b_i[3:2], kern_sel_i)};
    k_hl = {4'h0, kern(a_i[3:2], b_i[1:0], kern_sel_i)};
    k_hh = {4'h0, kern(a_i[3:2], b_i[3:2], kern_sel_i)};
    p_o  = k_ll + ((k_lh + k_hl) << 2) + (k_hh << 4);
  end

endmodule

// File: rtl/axrm8_seq_ctrl.sv
// Sequential 8x8 multiplier: one 4x4 core reused over four cycles with
// shift-accumulate, valid/ready on both sides and a saturating op counter.
module axrm8_seq_ctrl
  import axrm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_approx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_p,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e           state_q, state_d;
  logic [1:0]       step_q, step_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic             approx_q, approx_d;
  logic [15:0]      acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]  a_nib, b_nib;
  logic [7:0]  core_p;
  logic [15:0] part;

  // step[1] selects the high nibble of a, step[0] the high nibble of b.
  assign a_nib = step_q[1] ? a_q[7:4] : a_q[3:0];
  assign b_nib = step_q[0] ? b_q[7:4] : b_q[3:0];

  axrm4_core u_core (
    .a_i        (a_nib),
    .b_i        (b_nib),
    .kern_sel_i (approx_q),
    .p_o        (core_p)
  );

  assign part = {8'h00, core_p} << SHIFT_TBL[step_q];

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in_a;
          b_d      = in_b;
          approx_d = in_approx;
          acc_d    = '0;
          step_d   = 2'd0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d  = acc_q + part;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= KERN_EXACT;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_p     = acc_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_axrm8_seq_ctrl.sv
// Directed bench for axrm8_seq_ctrl with a scoreboard queue of expected products;
// a second instance with a 2-bit counter shares the stimulus to cover saturation.
module tb_axrm8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_approx, out_ready;
  logic [7:0]  in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [15:0] out_p, op_count;
  logic        in_ready_s, out_valid_s, busy_s;
  logic [15:0] out_p_s;
  logic [1:0]  op_count_s;

  int checks = 0;
  int errors = 0;
  int ops_done = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  axrm8_seq_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .busy(busy), .op_count(op_count)
  );

  axrm8_seq_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_approx(in_approx), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_p(out_p_s), .busy(busy_s), .op_count(op_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact mode is a plain multiply; approximate mode sums the
  // approximate 2x2 kernel over every 2-bit digit pair at weight 4^(i+j).
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic ap);
    int sum;
    if (!ap) return 16'(int'(a) * int'(b));
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int x, y, k;
        x = (int'(a) >> (2 * i)) & 3;
        y = (int'(b) >> (2 * j)) & 3;
        k = 4 * ((x >> 1) & (y >> 1)) + 3 * (x & y & 1);
        sum += k << (2 * (i + j));
      end
    end
    return 16'(sum);
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ap,
                        input int hold, input bit scramble);
    int lat;
    logic [15:0] exp_p, held;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_approx = ap; in_valid = 1'b1;
    sb_q.push_back(model(a, b, ap));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        in_a = 8'($urandom); in_b = 8'($urandom); in_approx = 1'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd4);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      exp_p = '0;
    end else begin
      exp_p = sb_q.pop_front();
    end
    check("out_p", 32'(out_p), 32'(exp_p));
    held = out_p;
    for (int c = 0; c < hold; c++) begin
      in_valid = 1'b1; in_a = 8'(c + 7); in_b = 8'(c + 9); in_approx = 1'b0;
      @(negedge clk);
      check("hold_out_p", 32'(out_p), 32'(held));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    ops_done++;
    check("after_hs_out_valid", 32'(out_valid), 32'd0);
    check("after_hs_in_ready", 32'(in_ready), 32'd1);
    check("after_hs_busy", 32'(busy), 32'd0);
    check("op_count", 32'(op_count), 32'(ops_done));
    check("op_count_sat", 32'(op_count_s), 32'((ops_done > 3) ? 3 : ops_done));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_approx = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p", 32'(out_p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);

    // Abort: accept, reach step 2, then assert reset asynchronously.
    in_a = 8'd255; in_b = 8'd255; in_approx = 1'b0; in_valid = 1'b1;
    sb_q.push_back(model(8'd255, 8'd255, 1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    check("run_busy", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_p", 32'(out_p), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    void'(sb_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end

    run_op(8'd255, 8'd255, 1'b0, 0, 1'b0);
    run_op(8'd200, 8'd3,   1'b0, 0, 1'b0);
    run_op(8'd255, 8'd255, 1'b1, 0, 1'b0);
    check("approx_ref", 32'(model(8'd255, 8'd255, 1'b1)), 32'd50575);
    run_op(8'd2,   8'd3,   1'b1, 0, 1'b0);
    run_op(8'd1,   8'd1,   1'b1, 0, 1'b0);
    run_op(8'd173, 8'd94,  1'b0, 0, 1'b1);
    run_op(8'd219, 8'd61,  1'b1, 0, 1'b1);
    run_op(8'd77,  8'd142, 1'b0, 10, 1'b0);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
